mac_row_n: RTL

- Parametrised weight-stationary MAC row holding NUM_MAC independent lanes. Successor to the fixed four-lane row.
- Each lane has a double-buffered weight (shadow and active) with validity tracking.
- Each lane registers activation pass-through and a signed accumulate-chain stage, with optional saturation and a per-cycle bypass mode.
- Sits between systolic rows: activations/valids move along the row direction, partial sums and weight-load beats move down the column.

---
 rtl/bna_mac_pkg.sv | 43 ++++
 rtl/mac_cell.sv | 87 ++++++++
 rtl/mac_row_n.sv | 71 +++++++
 3 files changed

// File: rtl/bna_mac_pkg.sv
// Shared defaults and helpers for the weight-stationary MAC row.
package bna_mac_pkg;

  localparam int DEF_NUM_MAC       = 4;
  localparam int DEF_MANT_WIDTH    = 7;
  localparam int DEF_WEIGHT_WIDTH  = 8;
  localparam int DEF_MAC_ACC_WIDTH = 48;

  // Widest accumulator the shared adder helper supports.
  localparam int ACC_MAX_W = 64;

  // Bit offset of lane 'lane' inside a packed per-lane bus.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  // Adds two values that are sign-extended from 'w' bits. The result is
  // either clamped to the signed w-bit range or wrapped to w bits.
  // The result is sign-extended back to ACC_MAX_W.
  function automatic logic signed [ACC_MAX_W-1:0] sat_add(
    input logic signed [ACC_MAX_W-1:0] a,
    input logic signed [ACC_MAX_W-1:0] b,
    input int                          w,
    input logic                        sat
  );
    logic signed [ACC_MAX_W:0] sum;
    logic signed [ACC_MAX_W:0] hi;
    logic signed [ACC_MAX_W:0] lo;
    logic signed [ACC_MAX_W:0] res;
    sum = {a[ACC_MAX_W-1], a} + {b[ACC_MAX_W-1], b};
    hi  = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo  = -hi - 65'sd1;
    if (sat) begin
      if (sum > hi)      res = hi;
      else if (sum < lo) res = lo;
      else               res = sum;
    end else begin
      res = (sum <<< (ACC_MAX_W + 1 - w)) >>> (ACC_MAX_W + 1 - w);
    end
    return $signed(res[ACC_MAX_W-1:0]);
  endfunction

endpackage

// File: rtl/mac_cell.sv
// One MAC lane: double-buffered weight, activation pass-through and a
// signed accumulate-chain stage with optional saturation.
module mac_cell
  import bna_mac_pkg::*;
#(
  parameter int MANT_WIDTH    = DEF_MANT_WIDTH,
  parameter int WEIGHT_WIDTH  = DEF_WEIGHT_WIDTH,
  parameter int MAC_ACC_WIDTH = DEF_MAC_ACC_WIDTH,
  parameter int SATURATE      = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic signed [MANT_WIDTH-1:0]    act_i,
  input  logic                            act_valid_i,
  input  logic signed [MAC_ACC_WIDTH-1:0] acc_i,
  input  logic                            mode_bypass_i,
  input  logic signed [WEIGHT_WIDTH-1:0]  load_weight_i,
  input  logic                            load_valid_i,
  input  logic                            set_weight_i,
  input  logic                            swap_ok_i,
  output logic [MANT_WIDTH-1:0]           act_o,
  output logic                            act_valid_o,
  output logic [MAC_ACC_WIDTH-1:0]        acc_o,
  output logic [WEIGHT_WIDTH-1:0]         load_weight_o,
  output logic                            shadow_valid_o,
  output logic                            swap_err_o
);

  logic signed [MANT_WIDTH-1:0]              act_q;
  logic                                      act_valid_q;
  logic signed [MAC_ACC_WIDTH-1:0]           acc_q, acc_d;
  logic signed [WEIGHT_WIDTH-1:0]            shadow_q, active_q, fwd_q;
  logic                                      shadow_valid_q, active_valid_q, err_q;
  logic signed [MANT_WIDTH+WEIGHT_WIDTH-1:0] prod;
  logic                                      do_swap;

  assign do_swap = set_weight_i & swap_ok_i;
  assign prod    = act_i * active_q;

  // Next partial sum: accumulate only for a valid activation against a valid weight.
  always_comb begin
    acc_d = acc_i;
    if (act_valid_i && active_valid_q && !mode_bypass_i) begin
      acc_d = MAC_ACC_WIDTH'(sat_add(ACC_MAX_W'(acc_i), ACC_MAX_W'(prod),
                                     MAC_ACC_WIDTH, 1'(SATURATE != 0)));
    end
  end

  // Pipeline registers plus shadow/active weight bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q          <= '0;
      act_valid_q    <= 1'b0;
      acc_q          <= '0;
      shadow_q       <= '0;
      active_q       <= '0;
      fwd_q          <= '0;
      shadow_valid_q <= 1'b0;
      active_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      act_q       <= act_i;
      act_valid_q <= act_valid_i;
      acc_q       <= acc_d;
      if (load_valid_i) begin
        shadow_q <= load_weight_i;
        fwd_q    <= shadow_q;
      end
      // Active takes the pre-edge shadow, so a same-cycle load is not lost.
      if (do_swap) begin
        active_q       <= shadow_q;
        active_valid_q <= 1'b1;
      end
      if (load_valid_i)  shadow_valid_q <= 1'b1;
      else if (do_swap)  shadow_valid_q <= 1'b0;
      if (set_weight_i && !swap_ok_i) err_q <= 1'b1;
    end
  end

  assign act_o          = act_q;
  assign act_valid_o    = act_valid_q;
  assign acc_o          = acc_q;
  assign load_weight_o  = fwd_q;
  assign shadow_valid_o = shadow_valid_q;
  assign swap_err_o     = err_q;

endmodule

// File: rtl/mac_row_n.sv
// Row of NUM_MAC weight-stationary MAC lanes sharing load/swap control.
module mac_row_n
  import bna_mac_pkg::*;
#(
  parameter int NUM_MAC       = DEF_NUM_MAC,
  parameter int MANT_WIDTH    = DEF_MANT_WIDTH,
  parameter int WEIGHT_WIDTH  = DEF_WEIGHT_WIDTH,
  parameter int MAC_ACC_WIDTH = DEF_MAC_ACC_WIDTH,
  parameter int SATURATE      = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_MAC*MANT_WIDTH-1:0]    act_i,
  input  logic [NUM_MAC-1:0]               act_valid_i,
  input  logic [NUM_MAC*MAC_ACC_WIDTH-1:0] acc_i,
  input  logic                             mode_bypass_i,
  output logic [NUM_MAC*MANT_WIDTH-1:0]    act_o,
  output logic [NUM_MAC-1:0]               act_valid_o,
  output logic [NUM_MAC*MAC_ACC_WIDTH-1:0] acc_o,
  input  logic [NUM_MAC*WEIGHT_WIDTH-1:0]  load_weight_i,
  input  logic                             load_valid_i,
  output logic [NUM_MAC*WEIGHT_WIDTH-1:0]  load_weight_o,
  output logic                             load_valid_o,
  input  logic                             set_weight_i,
  output logic                             weight_ready_o,
  output logic                             swap_err_o
);

  logic [NUM_MAC-1:0] shadow_valid;
  logic [NUM_MAC-1:0] lane_err;
  logic               load_valid_q;

  // A swap is legal only when every lane holds a fresh shadow weight.
  assign weight_ready_o = &shadow_valid;
  assign swap_err_o     = |lane_err;

  for (genvar k = 0; k < NUM_MAC; k++) begin : g_lane
    mac_cell #(
      .MANT_WIDTH   (MANT_WIDTH),
      .WEIGHT_WIDTH (WEIGHT_WIDTH),
      .MAC_ACC_WIDTH(MAC_ACC_WIDTH),
      .SATURATE     (SATURATE)
    ) u_cell (
      .clk           (clk),
      .rst_n         (rst_n),
      .act_i         (act_i[lane_lsb(k, MANT_WIDTH) +: MANT_WIDTH]),
      .act_valid_i   (act_valid_i[k]),
      .acc_i         (acc_i[lane_lsb(k, MAC_ACC_WIDTH) +: MAC_ACC_WIDTH]),
      .mode_bypass_i (mode_bypass_i),
      .load_weight_i (load_weight_i[lane_lsb(k, WEIGHT_WIDTH) +: WEIGHT_WIDTH]),
      .load_valid_i  (load_valid_i),
      .set_weight_i  (set_weight_i),
      .swap_ok_i     (weight_ready_o),
      .act_o         (act_o[lane_lsb(k, MANT_WIDTH) +: MANT_WIDTH]),
      .act_valid_o   (act_valid_o[k]),
      .acc_o         (acc_o[lane_lsb(k, MAC_ACC_WIDTH) +: MAC_ACC_WIDTH]),
      .load_weight_o (load_weight_o[lane_lsb(k, WEIGHT_WIDTH) +: WEIGHT_WIDTH]),
      .shadow_valid_o(shadow_valid[k]),
      .swap_err_o    (lane_err[k])
    );
  end

  // Load-beat valid travels down the column one row per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) load_valid_q <= 1'b0;
    else        load_valid_q <= load_valid_i;
  end

  assign load_valid_o = load_valid_q;

endmodule
